lumped_delay_line: RTL and testbench

Clocked, parametrised successor to the lumped-delay AND tree. Computes a per-bit four-input AND (`(a&b)&(c&d)`) on WIDTH independent channels and delivers each result after a lumped, runtime-programmable latency of 1..MAX_DELAY clock cycles. A valid flag travels with each sample. Used wherever a fixed gate-level output delay must become a cycle-accurate, reconfigurable pipeline delay in synchronous logic.

---
 rtl/lumped_delay_line.sv | 123 ++++++++++++
 tb/tb_lumped_delay_line.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lumped_delay_line.sv
// Four-input per-bit AND delivered after a runtime-programmable lumped latency of 1..MAX_DELAY cycles.
// Build option: define LUMPED_DELAY_HOLD_EN to make out hold the last valid result while out_valid=0.
module lumped_delay_line #(
  parameter int WIDTH       = 4,
  parameter int MAX_DELAY   = 16,
  parameter int RESET_DELAY = 10,
  parameter int DW          = $clog2(MAX_DELAY)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  input  logic [DW-1:0]    delay_sel,
  input  logic             delay_load,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  // Drain counter must hold cur_delay+1, which reaches MAX_DELAY.
  localparam int CW = DW + 1;

  localparam logic [DW-1:0] RESET_CODE = DW'(RESET_DELAY);
  localparam logic [DW-1:0] MAX_CODE   = DW'(MAX_DELAY - 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    cur_q, cur_d;
  logic [DW-1:0]    pend_q, pend_d;
  logic [WIDTH:0]   sr_q [MAX_DELAY];
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] and_res;
  logic [DW-1:0]    sel_sat;
  logic             accept;
  logic             drain_done;
  logic [WIDTH:0]   tap;

  assign and_res = (a & b) & (c & d);
  assign sel_sat = (delay_sel > MAX_CODE) ? MAX_CODE : delay_sel;
  assign accept  = in_valid & (state_q == ST_RUN);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    drain_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (delay_load) begin
          pend_d  = sel_sat;
          cnt_d   = {1'b0, cur_q} + CW'(1);
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          cur_d      = pend_q;
          state_d    = ST_RUN;
          drain_done = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    tap         = sr_q[cur_q];
    out_valid_d = tap[WIDTH];
    if (tap[WIDTH]) begin
      out_d = tap[WIDTH-1:0];
    end else begin
`ifdef LUMPED_DELAY_HOLD_EN
      out_d = out_q;
`else
      out_d = '0;
`endif
    end
  end

  // Every valid sample has emerged when the drain completes; clearing the
  // valid bits stops stale deep entries reappearing under a longer delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      cur_q       <= RESET_CODE;
      pend_q      <= RESET_CODE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < MAX_DELAY; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sr_q[0]     <= {accept, and_res};
      for (int i = 1; i < MAX_DELAY; i++) begin
        sr_q[i] <= {sr_q[i-1][WIDTH] & ~drain_done, sr_q[i-1][WIDTH-1:0]};
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_lumped_delay_line.sv
// Directed bench for lumped_delay_line (MAX_DELAY=12 so delay-code saturation is reachable).
module tb_lumped_delay_line;
  localparam int WIDTH       = 4;
  localparam int MAX_DELAY   = 12;
  localparam int RESET_DELAY = 10;
  localparam int DW          = $clog2(MAX_DELAY);

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] a, b, c, d;
  logic             in_valid;
  logic [DW-1:0]    delay_sel;
  logic             delay_load;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  logic chk_en = 1'b0;
  logic [WIDTH:0]   exp_tbl [0:2047];
  logic [WIDTH-1:0] last_val = '0;

  lumped_delay_line #(
    .WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .RESET_DELAY(RESET_DELAY)
  ) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d),
    .in_valid(in_valid), .delay_sel(delay_sel), .delay_load(delay_load),
    .out(out), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Advance to the next falling edge and compare outputs against the expected table.
  task automatic cyc();
    logic [WIDTH:0]   e;
    logic [WIDTH-1:0] eo;
    @(negedge clk);
    cyc_n++;
    if (chk_en) begin
      e = exp_tbl[cyc_n];
      if (e[WIDTH]) begin
        eo       = e[WIDTH-1:0];
        last_val = eo;
      end else begin
`ifdef LUMPED_DELAY_HOLD_EN
        eo = last_val;
`else
        eo = '0;
`endif
      end
      check("out_valid", 32'(out_valid), 32'(e[WIDTH]));
      check("out", 32'(out), 32'(eo));
    end
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    delay_load = 1'b0;
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    c = 4'($urandom_range(0, 15));
    d = 4'($urandom_range(0, 15));
  endtask

  // Sample is clocked at the next rising edge; lat is the hand-set latency in cycles.
  task automatic send(input logic [3:0] av, input logic [3:0] bv, input logic [3:0] cv,
                      input logic [3:0] dv, input logic [3:0] ev, input int lat);
    a = av; b = bv; c = cv; d = dv;
    in_valid = 1'b1;
    exp_tbl[cyc_n + lat + 1] = {1'b1, ev};
  endtask

  task automatic clear_future();
    for (int i = cyc_n + 1; i < 2048; i++) exp_tbl[i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] stream_v [4];
    stream_v = '{4'hF, 4'h7, 4'hB, 4'hD};
    for (int i = 0; i < 2048; i++) exp_tbl[i] = '0;
    reset = 1'b1;
    delay_sel = '0;
    idle();
    cyc();
    cyc();
    chk_en = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    cyc();
    check("reset_busy2", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (2) cyc();

    // Single sample, default latency 11
    send(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 11);
    cyc();
    idle();
    repeat (14) cyc();

    // Back-to-back stream
    for (int i = 0; i < 4; i++) begin
      send(stream_v[i], 4'hF, 4'hF, 4'hF, stream_v[i], 11);
      cyc();
    end
    idle();
    repeat (14) cyc();

    // Three in flight, then change delay to code 2 while they drain
    send(4'h3, 4'h7, 4'hF, 4'h5, 4'h1, 11);
    cyc();
    send(4'hE, 4'hF, 4'h6, 4'hF, 4'h6, 11);
    cyc();
    send(4'h9, 4'hB, 4'hF, 4'hD, 4'h9, 11);
    cyc();
    idle();
    check("busy_before_load", 32'(busy), 32'd0);
    delay_load = 1'b1;
    delay_sel  = 4'd2;
    cyc();
    for (int k = 1; k <= 11; k++) begin
      check("busy_drain_a", 32'(busy), 32'd1);
      in_valid   = 1'b1;
      a = 4'hF; b = 4'hF; c = 4'hF; d = 4'hF;
      delay_load = (k == 4);
      delay_sel  = 4'd7;
      cyc();
    end
    check("busy_after_drain_a", 32'(busy), 32'd0);
    delay_load = 1'b0;
    send(4'h6, 4'hF, 4'hF, 4'h7, 4'h6, 3);
    cyc();
    idle();
    repeat (6) cyc();

    // Code 15 saturates to 11: latency 12 (drain from code 2 lasts 3 cycles)
    delay_load = 1'b1;
    delay_sel  = 4'hF;
    cyc();
    idle();
    repeat (3) begin
      check("busy_drain_b", 32'(busy), 32'd1);
      cyc();
    end
    check("busy_after_drain_b", 32'(busy), 32'd0);
    send(4'hA, 4'hF, 4'hF, 4'hE, 4'hA, 12);
    cyc();
    idle();
    repeat (14) cyc();

    // Load and sample on the same cycle; second load during drain ignored
    send(4'h5, 4'hF, 4'hD, 4'hF, 4'h5, 12);
    delay_load = 1'b1;
    delay_sel  = 4'd10;
    cyc();
    idle();
    for (int k = 1; k <= 12; k++) begin
      check("busy_drain_c", 32'(busy), 32'd1);
      delay_load = (k == 2);
      delay_sel  = 4'd0;
      cyc();
    end
    check("busy_after_drain_c", 32'(busy), 32'd0);
    delay_load = 1'b0;
    send(4'hC, 4'hF, 4'hF, 4'hF, 4'hC, 11);
    cyc();
    idle();
    repeat (14) cyc();

    // Reset mid-drain discards in-flight samples and the pending delay
    a = 4'hF; b = 4'hF; c = 4'hF; d = 4'hF;
    in_valid = 1'b1;
    cyc();
    delay_load = 1'b1;
    delay_sel  = 4'd3;
    cyc();
    idle();
    repeat (3) cyc();
    check("busy_pre_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    clear_future();
    last_val = '0;
    cyc();
    check("busy_post_reset", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (20) cyc();
    check("busy_idle_post_reset", 32'(busy), 32'd0);
    send(4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 11);
    cyc();
    idle();
    repeat (14) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
